// File: rtl/sipo_frame_ctrl.sv
// Serial-in/parallel-out frame controller: MSB-first capture, one-entry valid/ready output buffer.
// Optional even-parity bit per frame enabled by defining SIPO_PARITY_CHECK_EN.
module sipo_frame_ctrl #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d,
    input  logic             d_en,
    input  logic             sof,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             busy,
    output logic [CNT_W-1:0] bit_cnt,
    output logic             overrun,
    input  logic             clr_ovr,
    output logic             parity_err
);

    // Handshake: a word moves to the consumer on any rising edge where q_valid & q_ready;
    // q is held stable while q_valid=1 and keeps its value after being consumed.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] word;
    logic [CNT_W-1:0] cnt_next;
    logic             load_req;
    logic             last_bit;
`ifdef SIPO_PARITY_CHECK_EN
    logic             par_fail;
`endif

    assign shifted  = {sh[WIDTH-2:0], d};
    assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
    assign busy     = (state != IDLE);

    always_comb begin
        state_next = state;
        sh_next    = sh;
        cnt_next   = bit_cnt;
        load_req   = 1'b0;
        word       = shifted;
`ifdef SIPO_PARITY_CHECK_EN
        par_fail   = 1'b0;
`endif
        if (d_en) begin
            case (state)
                IDLE: begin
                    if (sof) begin
                        sh_next    = shifted;
                        cnt_next   = CNT_W'(1);
                        state_next = SHIFT;
                    end
                end
                SHIFT: begin
                    sh_next = shifted;
                    if (sof) begin
                        cnt_next = CNT_W'(1);
                    end else if (last_bit) begin
                        cnt_next = '0;
`ifdef SIPO_PARITY_CHECK_EN
                        // Completed word waits in sh for its parity bit.
                        state_next = PARITY;
`else
                        state_next = IDLE;
                        load_req   = 1'b1;
`endif
                    end else begin
                        cnt_next = bit_cnt + CNT_W'(1);
                    end
                end
`ifdef SIPO_PARITY_CHECK_EN
                PARITY: begin
                    if (sof) begin
                        sh_next    = shifted;
                        cnt_next   = CNT_W'(1);
                        state_next = SHIFT;
                    end else begin
                        word       = sh;
                        state_next = IDLE;
                        if (^{sh, d}) par_fail = 1'b1;
                        else          load_req = 1'b1;
                    end
                end
`endif
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            sh      <= '0;
            bit_cnt <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_next;
            sh      <= sh_next;
            bit_cnt <= cnt_next;
            if (load_req && (!q_valid || q_ready)) begin
                q       <= word;
                q_valid <= 1'b1;
            end else if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
            // A new drop outranks a simultaneous clear.
            if (load_req && q_valid && !q_ready) overrun <= 1'b1;
            else if (clr_ovr)                    overrun <= 1'b0;
        end
    end

`ifdef SIPO_PARITY_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) parity_err <= 1'b0;
        else     parity_err <= par_fail;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
